mem_access_unit: RTL



---
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Processor-side sequencer for the direct-mapped cache port: one load/store at a time, read misses stretched.
// Optional macro MEM_ACCESS_STATS_EN adds saturating load hit/miss counters (hit_count, miss_count).
module mem_access_unit #(
  parameter int memory_bits  = 5,
  parameter int MISS_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_write,
  input  logic [memory_bits-1:0] cpu_req_addr,
  input  logic [31:0]            cpu_req_wdata,
  output logic                   cpu_resp_valid,
  output logic [31:0]            cpu_resp_rdata,
  output logic                   cpu_resp_hit,
  output logic [memory_bits-1:0] fulladdress,
  output logic [31:0]            write_data,
  output logic                   write_signal,
  output logic                   read_signal,
  input  logic [31:0]            read_data,
  input  logic                   match
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] MISS  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   op_q, op_d;  // 1 = store
  logic [memory_bits-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   hit_q, hit_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          op_d    = cpu_req_write;
          addr_d  = cpu_req_addr;
          wdata_d = cpu_req_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_q) begin
          rdata_d = 32'd0;
          hit_d   = 1'b0;
          state_d = RESP;
        end else if (match) begin
          rdata_d = read_data;
          hit_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = 4'(MISS_LATENCY - 1);
          state_d = MISS;
        end
      end
      MISS: begin
        if (cnt_q == 4'd0) begin
          rdata_d = read_data;
          hit_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end

  // Strobes decode from state, so they can never overlap and drop with the state on reset.
  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESP);
  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_hit   = hit_q;
  assign fulladdress    = addr_q;
  assign write_data     = wdata_q;
  assign write_signal   = (state_q == ISSUE) && op_q;
  assign read_signal    = ((state_q == ISSUE) && !op_q) || (state_q == MISS);

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        load_done;

  assign load_done = (state_q == ISSUE) && !op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else if (load_done) begin
      if (match) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
